load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, 16, max cycles waiting for mem_ack before bus error (1..255).
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  datapath requests a load/store this cycle
- is_store  in  1  1=store, 0=load
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address (datapath alu_res)
- wdata  in  32  store data (datapath write_data)
- stall  out  1  freeze pc/datapath while high
- rdata  out  32  load result (datapath read_data)
- done  out  1  one-cycle pulse, access finished
- err  out  1  one-cycle pulse with done: misaligned, illegal funct3, or timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned bus address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  bus completion; mem_rdata valid same cycle
- mem_rdata  in  32  bus read word

Function
REQ-003 FSM states SHALL be IDLE, BUS, RESP.
REQ-004 IDLE with req_valid=1 SHALL latch is_store, funct3, addr, wdata and go to BUS if access legal, else to RESP with error flag set.
REQ-005 Legal: loads funct3 in {000,001,010,100,101}; stores funct3 in {000,001,010}; H needs addr[0]=0; W needs addr[1:0]=00.
REQ-006 BUS SHALL assert mem_req=1 with mem_we, mem_addr, mem_be, mem_wdata stable from latched values until mem_ack sampled high.
REQ-007 mem_ack=1 in BUS SHALL go to RESP; loads capture extracted result into rdata on that edge.
REQ-008 Timeout counter SHALL clear on BUS entry, increment each BUS cycle without ack; reaching TIMEOUT SHALL go to RESP with error, rdata unchanged.
REQ-009 RESP SHALL assert done=1 for exactly one cycle (err=1 if error), then go to IDLE.
REQ-010 stall SHALL be 1 when (IDLE and req_valid) or BUS; 0 in RESP and idle IDLE.
REQ-011 req_valid SHALL be ignored outside IDLE; mem_ack outside BUS ignored.
REQ-012 Byte enables: B = 0001<<addr[1:0]; H = addr[1]?1100:0011; W = 1111; mem_be=0000 when mem_req=0.
REQ-013 mem_wdata: SB replicates wdata[7:0] to all 4 lanes; SH replicates wdata[15:0] to both halves; SW passes wdata.
REQ-014 Load extraction: B/BU select byte lane addr[1:0], H/HU select half addr[1]; B/H sign-extend bit 7/15, BU/HU zero-extend; W passes mem_rdata.
REQ-015 rdata SHALL hold last successful load value; stores and errored accesses leave it unchanged.
REQ-016 Minimum access latency: accept edge -> BUS; ack in first BUS cycle -> RESP next; done 2 cycles after accept edge.
REQ-017 Erroring access SHALL never assert mem_req.

Reset
REQ-018 reset low SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, err=0, stall=0 (req_valid ignored while low), timeout counter 0.
REQ-019 Reset during BUS SHALL abort the access with no done pulse; first post-reset cycle is IDLE.

Verification
REQ-020 LB addr=0x1003, mem_rdata=0x80FF_1234, ack first BUS cycle -> mem_addr=0x1000, mem_be=1000, rdata=0xFFFF_FF80, done 2 cycles after accept, err=0.
REQ-021 SH addr=0x2002 wdata=0xDEAD_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, rdata unchanged.
REQ-022 LW addr=0x3001 -> no mem_req, done=err=1 one cycle after accept, stall high only in accept cycle.
REQ-023 LHU addr=0x0 with mem_ack held low, TIMEOUT=16 -> mem_req high 16 cycles, then done=err=1, rdata unchanged.
REQ-024 LW with ack delayed 3 cycles -> stall high through BUS, mem signals stable, rdata=mem_rdata at ack; back-to-back req_valid accepted in IDLE after RESP.
REQ-025 reset low during BUS -> mem_req drops asynchronously, no done, rdata=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: bridges single datapath load/store requests onto a simple
// req/ack memory bus, with alignment checking, lane steering and a bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        legal;
    logic [31:0] load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Legality of the incoming request, judged on the live inputs at accept.
    always_comb begin
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~is_store;
            3'b101:  legal = ~is_store & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        load_byte = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_val = {24'h0, load_byte};
            3'b001:  load_val = {{16{load_half[15]}}, load_half};
            3'b101:  load_val = {16'h0, load_half};
            default: load_val = mem_rdata;
        endcase
    end

    // NOTE: all state lives in flops updated with non-blocking assignments so
    // every register samples the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= 8'h0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the case leaves a variable unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = is_store;
                    funct3_d = funct3;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    cnt_d    = 8'h0;
                    err_d    = ~legal;
                    state_d  = legal ? BUS : RESP;
                end
            end
            BUS: begin
                if (mem_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (!store_q) rdata_d = load_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are forced to zero outside BUS so reset and idle look identical.
    always_comb begin
        mem_req   = (state_q == BUS);
        mem_we    = mem_req & store_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (mem_req) begin
            case (funct3_q[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
        done  = (state_q == RESP);
        err   = done & err_q;
        stall = ((state_q == IDLE) & req_valid & reset) | (state_q == BUS);
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// compared against a byte-lane reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = 32'h0;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, lane offset and lane arithmetic.
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int n = size_of(f3);
        if (n == 0 || f3 == 3'b110) return 0;
        if (st && f3[2]) return 0;
        return (a % n) == 0;
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int n = size_of(f3);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int n = size_of(f3);
        return 4'(((1 << n) - 1) << lane_off(f3, a));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int     n    = size_of(f3);
        longint mask = (64'd1 << (8 * n)) - 1;
        longint r    = 0;
        for (int i = 0; i < 4 / n; i++) r = r | ((longint'(wd) & mask) << (8 * n * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rw);
        int     n    = size_of(f3);
        longint mask = (64'd1 << (8 * n)) - 1;
        longint v    = (longint'(rw) >> (8 * lane_off(f3, a))) & mask;
        if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    // One access starting at a falling edge in IDLE; returns at a falling edge in IDLE.
    // delay = BUS cycles without ack before the acking cycle (>= TIMEOUT means never).
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int delay);
        bit legal    = is_legal(st, f3, a);
        bit timedout = 0;
        int k        = 0;
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        chk("stall_accept", 32'(stall), 32'd1);
        chk("mem_req_accept", 32'(mem_req), 32'd0);
        @(negedge clk);
        req_valid = 1'($urandom % 2);
        addr      = $urandom;
        wdata     = $urandom;
        funct3    = 3'($urandom);
        is_store  = 1'($urandom % 2);
        if (legal) begin
            while (1) begin
                chk("bus_mem_req", 32'(mem_req), 32'd1);
                chk("bus_mem_we", 32'(mem_we), 32'(st));
                chk("bus_mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("bus_mem_be", 32'(mem_be), 32'(exp_be(f3, a)));
                if (st) chk("bus_mem_wdata", mem_wdata, exp_wdata(f3, wd));
                chk("bus_stall", 32'(stall), 32'd1);
                chk("bus_done", 32'(done), 32'd0);
                if (k == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rw;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                if (k == delay) break;
                if (k == TIMEOUT - 1) begin
                    timedout = 1;
                    break;
                end
                k++;
            end
            if (!timedout && !st) exp_rdata = exp_load(f3, a, rw);
        end
        req_valid = 1'b0;
        mem_ack   = 1'($urandom % 2);
        mem_rdata = $urandom;
        chk("resp_done", 32'(done), 32'd1);
        chk("resp_err", 32'(err), 32'(!legal || timedout));
        chk("resp_stall", 32'(stall), 32'd0);
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        chk("resp_mem_be", 32'(mem_be), 32'd0);
        chk("resp_rdata", rdata, exp_rdata);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // LB from the top byte lane, sign-extended
        access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        chk("lb_rdata_literal", rdata, 32'hFFFF_FF80);

        // SH upper half, load result must be untouched
        access(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 0);
        chk("sh_rdata_literal", rdata, 32'hFFFF_FF80);

        // Misaligned LW errors without touching the bus
        access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);

        // Illegal store size and reserved funct3
        access(1'b1, 3'b100, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
        access(1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 0);

        // LHU with ack never arriving times out
        access(1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0, 1000);
        chk("timeout_rdata_literal", rdata, 32'hFFFF_FF80);

        // Ack on the very last allowed cycle still completes the load
        access(1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'hABCD_0000, TIMEOUT - 1);

        // LW with delayed ack followed immediately by another request
        access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 3);
        chk("lw_rdata_literal", rdata, 32'h1357_9BDF);
        access(1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 1);
        chk("lh_rdata_literal", rdata, 32'hFFFF_8001);

        for (int i = 0; i < 60; i++) begin
            automatic bit          st = 1'($urandom % 2);
            automatic logic [2:0]  f3 = 3'($urandom % 8);
            automatic logic [31:0] a  = $urandom;
            automatic int          dl = ($urandom % 10 == 0) ? 100 : int'($urandom % 4);
            access(st, f3, a, $urandom, $urandom, dl);
        end

        // Make rdata nonzero, then reset in the middle of a bus access
        access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0);
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0000_6000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        exp_rdata = 32'h0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        chk("postrst_done", 32'(done), 32'd0);
        chk("postrst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("postrst2_done", 32'(done), 32'd0);
        chk("postrst2_stall", 32'(stall), 32'd0);
        access(1'b0, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_9A00, 2);
        chk("postrst_lbu_literal", rdata, 32'h0000_009A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
